// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
// Shared helpers for the Gray-code receive path.
//   DEFAULT_WIDTH : default Gray/binary word width
//   MAX_WIDTH     : widest word the helper functions handle
//   gray2bin()    : Gray -> binary on a zero-extended MAX_WIDTH word
//   popcount()    : number of set bits in a MAX_WIDTH word
// -----------------------------------------------------------------------------
package gray_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned MAX_WIDTH     = 32;
  localparam int unsigned CNT_WIDTH     = 6;

  // Zero upper bits decode to zero, so a narrower word decodes correctly
  // when it is zero-extended to MAX_WIDTH before the call.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] gray);
    logic [MAX_WIDTH-1:0] bin;
    bin[MAX_WIDTH-1] = gray[MAX_WIDTH-1];
    for (int unsigned i = MAX_WIDTH - 1; i > 0; i--) begin
      bin[i-1] = bin[i] ^ gray[i-1];
    end
    return bin;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [MAX_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      cnt = cnt + {{(CNT_WIDTH-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray_to_binary_df.sv
// -----------------------------------------------------------------------------
// gray_to_binary_df
// Purely combinational Gray -> binary decoder.
//   g : Gray-coded word (WIDTH bits)
//   b : decoded binary word (WIDTH bits)
// -----------------------------------------------------------------------------
module gray_to_binary_df
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b
);

  logic [MAX_WIDTH-1:0] g_ext;
  logic [MAX_WIDTH-1:0] b_ext;

  always_comb begin
    g_ext = MAX_WIDTH'(g);
    b_ext = gray2bin(g_ext);
    b     = b_ext[WIDTH-1:0];
  end

endmodule

// File: rtl/gray_to_binary_rx.sv
// -----------------------------------------------------------------------------
// gray_to_binary_rx
// Receives a stream of Gray-coded samples, decodes each to binary through a
// two-stage pipeline and reports the modulo-2^WIDTH delta from the previous
// sample together with a flag for an illegal (multi-bit) Gray step.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   clr      : synchronous flush of pipeline and history
//   g        : Gray-coded sample          g_valid / g_ready : input handshake
//   b        : decoded binary value
//   delta    : (b - previous b) mod 2^WIDTH
//   step_err : Hamming distance from the previous Gray sample exceeds one
//   first    : first sample since reset/clr (no history to compare against)
//   b_valid / b_ready : output handshake
// -----------------------------------------------------------------------------
module gray_to_binary_rx
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] g,
  input  logic             g_valid,
  output logic             g_ready,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] delta,
  output logic             step_err,
  output logic             first,
  output logic             b_valid,
  input  logic             b_ready
);

  // Stage 1: raw Gray sample
  logic             s1_valid;
  logic [WIDTH-1:0] g1;

  // History of the last sample that entered stage 2
  logic             have_prev;
  logic [WIDTH-1:0] prev_g;
  logic [WIDTH-1:0] prev_b;

  logic             in_hs;
  logic             adv;
  logic [WIDTH-1:0] dec_b;
  logic [MAX_WIDTH-1:0] diff_ext;
  logic             multi_bit;

  gray_to_binary_df #(.WIDTH(WIDTH)) u_dec (
    .g (g1),
    .b (dec_b)
  );

  // Ready looks through the output register so a full pipeline keeps
  // streaming when downstream is ready.
  always_comb begin
    g_ready   = !clr && (!s1_valid || !b_valid || b_ready);
    in_hs     = g_valid && g_ready;
    adv       = s1_valid && (!b_valid || b_ready);
    diff_ext  = MAX_WIDTH'(g1 ^ prev_g);
    multi_bit = (popcount(diff_ext) > CNT_WIDTH'(1));
  end

  // Stage 1. An accepted sample and a stage-2 advance can coincide; the new
  // sample simply replaces the one moving on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      g1       <= '0;
    end else if (clr) begin
      s1_valid <= 1'b0;
    end else if (in_hs) begin
      s1_valid <= 1'b1;
      g1       <= g;
    end else if (adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 and history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid   <= 1'b0;
      b         <= '0;
      delta     <= '0;
      step_err  <= 1'b0;
      first     <= 1'b0;
      have_prev <= 1'b0;
      prev_g    <= '0;
      prev_b    <= '0;
    end else if (clr) begin
      b_valid   <= 1'b0;
      have_prev <= 1'b0;
    end else if (adv) begin
      b_valid   <= 1'b1;
      b         <= dec_b;
      first     <= !have_prev;
      delta     <= have_prev ? (dec_b - prev_b) : '0;
      step_err  <= have_prev && multi_bit;
      have_prev <= 1'b1;
      prev_g    <= g1;
      prev_b    <= dec_b;
    end else if (b_ready) begin
      b_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_to_binary_rx.sv
// -----------------------------------------------------------------------------
// tb_gray_to_binary_rx
// Self-checking bench for gray_to_binary_rx (WIDTH=4): table-driven directed
// groups, hand-written backpressure/clr/reset sequences and a randomized
// stream checked against a sample-level reference model.
// -----------------------------------------------------------------------------
module tb_gray_to_binary_rx;

  localparam int W = 4;
  localparam int N = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] g = '0;
  logic         g_valid = 1'b0;
  logic         g_ready;
  logic [W-1:0] b;
  logic [W-1:0] delta;
  logic         step_err;
  logic         first;
  logic         b_valid;
  logic         b_ready = 1'b1;

  always #5 clk = ~clk;

  gray_to_binary_rx #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .g        (g),
    .g_valid  (g_valid),
    .g_ready  (g_ready),
    .b        (b),
    .delta    (delta),
    .step_err (step_err),
    .first    (first),
    .b_valid  (b_valid),
    .b_ready  (b_ready)
  );

  typedef struct {
    logic [W-1:0] b;
    logic [W-1:0] delta;
    logic         err;
    logic         first;
    int           cyc;
  } exp_t;

  typedef struct {
    logic [W-1:0] g;
    logic [W-1:0] b;
    logic [W-1:0] delta;
    logic         err;
    logic         first;
  } vec_t;

  exp_t exp_q[$];
  exp_t got_q[$];
  vec_t vecs[25];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model history
  bit           m_have = 0;
  logic [W-1:0] m_pg = '0;
  int           m_pb = 0;

  bit           hold_pending = 0;
  logic [W-1:0] h_b, h_d;
  logic         h_e, h_f;
  bit           lat_chk = 0;
  logic         last_ready, last_bvalid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] enc(input int n);
    return W'(n ^ (n >> 1));
  endfunction

  // decode by searching the encoder's image
  function automatic int dec(input logic [W-1:0] gv);
    for (int n = 0; n < N; n++) if (enc(n) == gv) return n;
    return -1;
  endfunction

  task automatic model_flush();
    exp_q.delete();
    m_have = 0;
    hold_pending = 0;
  endtask

  task automatic model_accept(input logic [W-1:0] gd);
    exp_t e;
    int bin;
    bin = dec(gd);
    e.b = W'(bin);
    e.cyc = cyc;
    if (!m_have) begin
      e.delta = '0;
      e.err = 1'b0;
      e.first = 1'b1;
    end else begin
      e.delta = W'((bin - m_pb + N) % N);
      e.err = ($countones(gd ^ m_pg) > 1);
      e.first = 1'b0;
    end
    m_have = 1;
    m_pg = gd;
    m_pb = bin;
    exp_q.push_back(e);
  endtask

  // One clock: drive at negedge, sample 1 ns later, update the model.
  task automatic tick(input bit gv, input logic [W-1:0] gd, input bit br, input bit cl, output bit acc);
    exp_t e, o;
    @(negedge clk);
    g_valid = gv; g = gd; b_ready = br; clr = cl;
    #1;
    check("g_ready", 32'(g_ready), 32'(!cl && (exp_q.size() < 2 || br)));
    if (hold_pending) begin
      check("hold_valid", 32'(b_valid), 32'd1);
      check("hold_data", 32'({b, delta, step_err, first}), 32'({h_b, h_d, h_e, h_f}));
    end
    hold_pending = 0;
    if (exp_q.size() == 0) check("idle_b_valid", 32'(b_valid), 32'd0);
    if (b_valid && br) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output actual b=%0h required none", b);
      end else begin
        e = exp_q.pop_front();
        check("out", 32'({b, delta, step_err, first}), 32'({e.b, e.delta, e.err, e.first}));
        if (lat_chk) check("latency", 32'(cyc - e.cyc), 32'd2);
      end
      o.b = b; o.delta = delta; o.err = step_err; o.first = first; o.cyc = cyc;
      got_q.push_back(o);
    end
    if (b_valid && !br && !cl) begin
      hold_pending = 1;
      h_b = b; h_d = delta; h_e = step_err; h_f = first;
    end
    acc = gv && g_ready;
    if (acc) model_accept(gd);
    if (cl) model_flush();
    last_ready = g_ready;
    last_bvalid = b_valid;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; g_valid = 1'b0; clr = 1'b0;
    #1;
    check("rst_b_valid", 32'(b_valid), 32'd0);
    check("rst_outputs", 32'({b, delta, step_err, first}), 32'd0);
    check("rst_g_ready", 32'(g_ready), 32'd1);
    model_flush();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic feed(input logic [W-1:0] gd, input bit br);
    bit acc;
    acc = 0;
    for (int t = 0; t < 20 && !acc; t++) tick(1, gd, br, 0, acc);
    if (!acc) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted g=%0h", gd);
    end
  endtask

  task automatic drain(input int want);
    bit acc;
    for (int k = 0; k < 20 && got_q.size() < want; k++) tick(0, '0, 1, 0, acc);
    check("drain_count", 32'(got_q.size()), 32'(want));
  endtask

  task automatic run_group(input int s, input int e);
    bit acc;
    tick(0, '0, 1, 1, acc);
    got_q.delete();
    lat_chk = 1;
    for (int i = s; i < e; i++) feed(vecs[i].g, 1);
    drain(e - s);
    for (int i = s; i < e; i++) begin
      if (i - s < got_q.size())
        check($sformatf("vec%0d", i),
              32'({got_q[i-s].b, got_q[i-s].delta, got_q[i-s].err, got_q[i-s].first}),
              32'({vecs[i].b, vecs[i].delta, vecs[i].err, vecs[i].first}));
    end
    lat_chk = 0;
  endtask

  task automatic set_vec(input int i, input logic [W-1:0] gv, input logic [W-1:0] bv,
                         input logic [W-1:0] dv, input logic ev, input logic fv);
    vecs[i].g = gv; vecs[i].b = bv; vecs[i].delta = dv; vecs[i].err = ev; vecs[i].first = fv;
  endtask

  initial begin
    bit acc;
    int idx, rb, nb, sel;
    bit cand_ok;
    logic [W-1:0] cand;

    // legal sequence
    set_vec(0, 4'b0000, 4'd0, 4'd0, 0, 1);
    set_vec(1, 4'b0001, 4'd1, 4'd1, 0, 0);
    set_vec(2, 4'b0011, 4'd2, 4'd1, 0, 0);
    set_vec(3, 4'b0010, 4'd3, 4'd1, 0, 0);
    // wrap-around
    set_vec(4, 4'b1000, 4'd15, 4'd0, 0, 1);
    set_vec(5, 4'b0000, 4'd0, 4'd1, 0, 0);
    // illegal jump, then legal step from the erroneous sample
    set_vec(6, 4'b0000, 4'd0, 4'd0, 0, 1);
    set_vec(7, 4'b0011, 4'd2, 4'd2, 1, 0);
    set_vec(8, 4'b0010, 4'd3, 4'd1, 0, 0);
    // exhaustive decode of encoder outputs
    for (int i = 0; i < N; i++)
      set_vec(9 + i, enc(i), W'(i), (i == 0) ? 4'd0 : 4'd1, 0, (i == 0));

    do_reset();

    run_group(0, 4);
    run_group(4, 6);
    run_group(6, 9);
    run_group(9, 25);

    // backpressure: b_ready low for three cycles mid-stream
    tick(0, '0, 1, 1, acc);
    got_q.delete();
    idx = 0;
    for (int c = 0; c < 30 && (idx < 4 || got_q.size() < 4); c++) begin
      tick(idx < 4, (idx < 4) ? enc(idx) : '0, !(c >= 2 && c <= 4), 0, acc);
      if (c >= 2 && c <= 4) check("bp_g_ready_low", 32'(last_ready), 32'd0);
      if (acc) idx++;
    end
    check("bp_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check("bp_out", 32'({got_q[i].b, got_q[i].delta, got_q[i].err, got_q[i].first}),
            32'({W'(i), (i == 0) ? 4'd0 : 4'd1, 1'b0, (i == 0)}));

    // clr with two samples in flight
    tick(0, '0, 1, 1, acc);
    got_q.delete();
    feed(enc(5), 1);
    feed(enc(6), 0);
    tick(0, '0, 0, 1, acc);
    check("clr_g_ready", 32'(last_ready), 32'd0);
    tick(0, '0, 1, 0, acc);
    check("clr_flush_b_valid", 32'(last_bvalid), 32'd0);
    feed(enc(9), 1);
    drain(1);
    if (got_q.size() > 0)
      check("clr_next", 32'({got_q[0].b, got_q[0].delta, got_q[0].err, got_q[0].first}),
            32'({4'd9, 4'd0, 1'b0, 1'b1}));

    // reset with two samples in flight
    tick(0, '0, 1, 1, acc);
    got_q.delete();
    feed(enc(3), 1);
    feed(enc(4), 0);
    do_reset();
    tick(0, '0, 1, 0, acc);
    check("rst_flush_b_valid", 32'(last_bvalid), 32'd0);
    feed(enc(12), 1);
    drain(1);
    if (got_q.size() > 0)
      check("rst_next", 32'({got_q[0].b, got_q[0].delta, got_q[0].err, got_q[0].first}),
            32'({4'd12, 4'd0, 1'b0, 1'b1}));

    // randomized stream, mostly legal steps with occasional jumps
    rb = 0;
    cand_ok = 0;
    cand = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!cand_ok) begin
        sel = $urandom_range(0, 9);
        if (sel < 6)      nb = (rb + 1) % N;
        else if (sel < 7) nb = rb;
        else if (sel < 8) nb = (rb + N - 1) % N;
        else              nb = $urandom_range(0, N - 1);
        cand = enc(nb);
        cand_ok = 1;
      end
      if (c % 700 == 699) begin
        do_reset();
      end else begin
        tick($urandom_range(0, 9) < 8, cand, $urandom_range(0, 3) != 0,
             $urandom_range(0, 149) == 0, acc);
        if (acc) begin
          rb = nb;
          cand_ok = 0;
        end
      end
    end
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) tick(0, '0, 1, 0, acc);
    check("final_drain_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // absolute watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
